mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter, with burst lock, in front of a single-ported memory.
// Read returns are routed back to the issuing port through a READ_LATENCY-deep tag pipeline.
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              lock0,
   input  logic              lock1,
   output logic              ack0,
   output logic              ack1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   logic                    last_grant_q, last_grant_d;
   logic                    lock_valid_q, lock_valid_d;
   logic                    lock_port_q, lock_port_d;
   logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
   logic [READ_LATENCY-1:0] pipe_port_q, pipe_port_d;

   logic                    grant_valid;
   logic                    grant_port;
   logic                    sel_we;
   logic                    sel_lock;
   logic [ADDR_W-1:0]       sel_addr;
   logic [DATA_W-1:0]       sel_wdata;

   // A held lock only matters on a tie: an owner that drops req simply loses.
   always_comb begin
      grant_valid = 1'b0;
      grant_port  = 1'b0;
      if (!rst) begin
         if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_port  = lock_valid_q ? lock_port_q : ~last_grant_q;
         end else if (req0) begin
            grant_valid = 1'b1;
            grant_port  = 1'b0;
         end else if (req1) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_we    = grant_port ? we1    : we0;
      sel_lock  = grant_port ? lock1  : lock0;
      sel_addr  = grant_port ? addr1  : addr0;
      sel_wdata = grant_port ? wdata1 : wdata0;

      ack0           = grant_valid && !grant_port;
      ack1           = grant_valid && grant_port;
      mem_we         = grant_valid && sel_we;
      mem_write_addr = (grant_valid && sel_we)  ? sel_addr  : '0;
      mem_write_data = (grant_valid && sel_we)  ? sel_wdata : '0;
      mem_read_addr  = (grant_valid && !sel_we) ? sel_addr  : '0;

      rvalid0 = pipe_valid_q[READ_LATENCY-1] && !pipe_port_q[READ_LATENCY-1];
      rvalid1 = pipe_valid_q[READ_LATENCY-1] &&  pipe_port_q[READ_LATENCY-1];
      rdata   = mem_read_data;
   end

   always_comb begin
      last_grant_d = grant_valid ? grant_port : last_grant_q;
      lock_valid_d = grant_valid && sel_lock;
      lock_port_d  = grant_port;

      pipe_valid_d    = pipe_valid_q;
      pipe_port_d     = pipe_port_q;
      pipe_valid_d[0] = grant_valid && !sel_we;
      pipe_port_d[0]  = grant_port;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
         pipe_port_d[i]  = pipe_port_q[i-1];
      end
   end

   // last_grant resets to port 1 so that port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         lock_valid_q <= 1'b0;
         lock_port_q  <= 1'b0;
         pipe_valid_q <= '0;
         pipe_port_q  <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         lock_valid_q <= lock_valid_d;
         lock_port_q  <= lock_port_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_port_q  <= pipe_port_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 1 and 2) share stimulus and are
// compared every cycle against a rule-level model, plus directed literal expectations.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   logic req0, req1, we0, we1, lock0, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;

   logic [1:0]         ack0_v, ack1_v, rvalid0_v, rvalid1_v, mem_we_v;
   logic [1:0][DW-1:0] rdata_v, mem_write_data_v, mem_read_data_v;
   logic [1:0][AW-1:0] mem_read_addr_v, mem_write_addr_v;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1),
      .ack0(ack0_v[0]), .ack1(ack1_v[0]),
      .rvalid0(rvalid0_v[0]), .rvalid1(rvalid1_v[0]), .rdata(rdata_v[0]),
      .mem_we(mem_we_v[0]), .mem_read_addr(mem_read_addr_v[0]),
      .mem_write_addr(mem_write_addr_v[0]), .mem_write_data(mem_write_data_v[0]),
      .mem_read_data(mem_read_data_v[0])
   );

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1),
      .ack0(ack0_v[1]), .ack1(ack1_v[1]),
      .rvalid0(rvalid0_v[1]), .rvalid1(rvalid1_v[1]), .rdata(rdata_v[1]),
      .mem_we(mem_we_v[1]), .mem_read_addr(mem_read_addr_v[1]),
      .mem_write_addr(mem_write_addr_v[1]), .mem_write_data(mem_write_data_v[1]),
      .mem_read_data(mem_read_data_v[1])
   );

   initial forever #5 clk = ~clk;

   // Memory emulation: synchronous read sampled at issue, delayed to each instance's latency.
   bit [DW-1:0] mem_arr [65536];
   bit [DW-1:0] rd_pipe1;
   bit [DW-1:0] rd_pipe2 [2];

   always @(posedge clk) begin
      rd_pipe1    <= mem_arr[mem_read_addr_v[0]];
      rd_pipe2[0] <= mem_arr[mem_read_addr_v[1]];
      rd_pipe2[1] <= rd_pipe2[0];
      if (mem_we_v[0]) mem_arr[mem_write_addr_v[0]] <= mem_write_data_v[0];
   end

   assign mem_read_data_v[0] = rd_pipe1;
   assign mem_read_data_v[1] = rd_pipe2[1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: arbitration rules plus a queue of expected read returns per instance.
   typedef struct {int due; int port; logic [DW-1:0] data;} ret_t;

   bit          model_en = 1'b0;
   int          cyc      = 0;
   int          m_last   = 1;
   int          m_lock   = -1;
   bit [DW-1:0] model_mem [65536];
   ret_t        rq1[$];
   ret_t        rq2[$];

   always @(negedge clk) begin
      int          w;
      bit          w_we, w_lock;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_data;
      bit          ev0, ev1;
      logic [DW-1:0] ed;
      ret_t        r;
      if (model_en) begin
         w = -1;
         if (!rst) begin
            if (req0 && req1)  w = (m_lock >= 0) ? m_lock : 1 - m_last;
            else if (req0)     w = 0;
            else if (req1)     w = 1;
         end
         w_we   = (w == 1) ? we1    : we0;
         w_lock = (w == 1) ? lock1  : lock0;
         w_addr = (w == 1) ? addr1  : addr0;
         w_data = (w == 1) ? wdata1 : wdata0;
         if (w < 0) begin
            w_we = 1'b0; w_lock = 1'b0; w_addr = '0; w_data = '0;
         end
         for (int d = 0; d < 2; d++) begin
            check($sformatf("ack0_l%0d", d + 1), 32'(ack0_v[d]), 32'(w == 0));
            check($sformatf("ack1_l%0d", d + 1), 32'(ack1_v[d]), 32'(w == 1));
            check($sformatf("mem_we_l%0d", d + 1), 32'(mem_we_v[d]), 32'(w_we));
            check($sformatf("mem_read_addr_l%0d", d + 1), 32'(mem_read_addr_v[d]),
                  32'((w >= 0 && !w_we) ? w_addr : '0));
            check($sformatf("mem_write_addr_l%0d", d + 1), 32'(mem_write_addr_v[d]),
                  32'(w_we ? w_addr : '0));
            check($sformatf("mem_write_data_l%0d", d + 1), 32'(mem_write_data_v[d]),
                  32'(w_we ? w_data : '0));
            ev0 = 1'b0; ev1 = 1'b0; ed = '0;
            if (d == 0 && rq1.size() > 0 && rq1[0].due == cyc) begin
               r = rq1.pop_front(); ev0 = (r.port == 0); ev1 = (r.port == 1); ed = r.data;
            end
            if (d == 1 && rq2.size() > 0 && rq2[0].due == cyc) begin
               r = rq2.pop_front(); ev0 = (r.port == 0); ev1 = (r.port == 1); ed = r.data;
            end
            check($sformatf("rvalid0_l%0d", d + 1), 32'(rvalid0_v[d]), 32'(ev0));
            check($sformatf("rvalid1_l%0d", d + 1), 32'(rvalid1_v[d]), 32'(ev1));
            if (ev0 || ev1) check($sformatf("rdata_l%0d", d + 1), 32'(rdata_v[d]), 32'(ed));
         end
         if (rst) begin
            m_last = 1; m_lock = -1; rq1.delete(); rq2.delete();
         end else if (w >= 0) begin
            m_last = w;
            m_lock = w_lock ? w : -1;
            if (w_we) model_mem[w_addr] = w_data;
            else begin
               rq1.push_back('{cyc + 1, w, model_mem[w_addr]});
               rq2.push_back('{cyc + 2, w, model_mem[w_addr]});
            end
         end else begin
            m_lock = -1;
         end
      end
      cyc++;
   end

   task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input bit l0,
                        input bit r1, input bit w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1, input bit l1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int n_ack0, n_ack1, n_rv0, n_rv1;

   initial begin
      rst = 1'b1;
      drive(1, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0);
      step();
      model_en = 1'b1;

      // Reset held with both ports requesting
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("reset_ack0", 32'(ack0_v[0]), 32'd0);
         check("reset_ack1", 32'(ack1_v[0]), 32'd0);
         check("reset_mem_we", 32'(mem_we_v[0]), 32'd0);
         step();
      end
      rst = 1'b0;
      @(negedge clk);
      check("first_tie_ack0", 32'(ack0_v[0]), 32'd1);
      check("first_tie_ack1", 32'(ack1_v[0]), 32'd0);
      step();

      // Preload two words, then both ports read continuously
      drive(1, 1, 16'h0010, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000, 0);
      step();
      drive(0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0020, 16'h2222, 0);
      step();
      drive(1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'h0020, 16'h0000, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("alt_ack0", 32'(ack0_v[0]), 32'(k % 2 == 0));
         check("alt_ack1", 32'(ack1_v[0]), 32'(k % 2 == 1));
         if (k > 0) begin
            check("alt_rvalid0", 32'(rvalid0_v[0]), 32'(k % 2 == 1));
            check("alt_rvalid1", 32'(rvalid1_v[0]), 32'(k % 2 == 0));
            check("alt_rdata", 32'(rdata_v[0]), (k % 2 == 1) ? 32'h1111 : 32'h2222);
         end
         step();
      end
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
      @(negedge clk);
      check("alt_last_rvalid1", 32'(rvalid1_v[0]), 32'd1);
      check("alt_last_rdata", 32'(rdata_v[0]), 32'h2222);
      step();

      // Port 1 writes, port 0 reads the same address back
      drive(0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0100, 16'hBEEF, 0);
      @(negedge clk);
      check("wr_mem_we", 32'(mem_we_v[0]), 32'd1);
      check("wr_addr", 32'(mem_write_addr_v[0]), 32'h0100);
      check("wr_data", 32'(mem_write_data_v[0]), 32'hBEEF);
      step();
      drive(1, 0, 16'h0100, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
      @(negedge clk);
      check("rd_ack0", 32'(ack0_v[0]), 32'd1);
      check("rd_addr", 32'(mem_read_addr_v[0]), 32'h0100);
      step();
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
      @(negedge clk);
      check("raw_rvalid0_l1", 32'(rvalid0_v[0]), 32'd1);
      check("raw_rdata_l1", 32'(rdata_v[0]), 32'hBEEF);
      step();
      @(negedge clk);
      check("raw_rvalid0_l2", 32'(rvalid0_v[1]), 32'd1);
      check("raw_rdata_l2", 32'(rdata_v[1]), 32'hBEEF);
      step();

      // Locked burst from port 1 while port 0 keeps requesting
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 16'h0010, 16'h0000, 0, 1, 1, 16'(16'h0200 + k), 16'(k), k < 3);
         @(negedge clk);
         check("lock_ack1", 32'(ack1_v[0]), 32'(k < 4));
         check("lock_ack0", 32'(ack0_v[0]), 32'(k == 4));
         if (k < 4) check("lock_waddr", 32'(mem_write_addr_v[0]), 32'(16'h0200 + k));
         step();
      end
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
      step();
      step();

      // Reset right after a read is accepted drops its return
      drive(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
      @(negedge clk);
      check("midrst_ack0", 32'(ack0_v[1]), 32'd1);
      step();
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("midrst_rvalid0_l2", 32'(rvalid0_v[1]), 32'd0);
         check("midrst_rvalid1_l2", 32'(rvalid1_v[1]), 32'd0);
         step();
         if (k == 1) rst = 1'b0;
      end

      // Single requester: five consecutive reads from port 0
      n_ack0 = 0; n_ack1 = 0; n_rv0 = 0; n_rv1 = 0;
      for (int k = 0; k < 7; k++) begin
         if (k < 5) drive(1, 0, 16'(16'h0020 + k), 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
         else       drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
         @(negedge clk);
         n_ack0 += int'(ack0_v[0]); n_ack1 += int'(ack1_v[0]);
         n_rv0  += int'(rvalid0_v[0]); n_rv1 += int'(rvalid1_v[0]);
         step();
      end
      check("single_ack0_count", 32'(n_ack0), 32'd5);
      check("single_rvalid0_count", 32'(n_rv0), 32'd5);
      check("single_ack1_count", 32'(n_ack1), 32'd0);
      check("single_rvalid1_count", 32'(n_rv1), 32'd0);

      // Randomized traffic on a small address window, with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               16'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               16'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 2) == 0);
         step();
      end
      rst = 1'b0;
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
      for (int k = 0; k < 4; k++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
